// File: rtl/i2c_target.sv
// I2C target: 7-bit address match, fixed 16-bit write (RX_DATA) and read (TX_DATA) transfers.
// Define I2C_TARGET_SYNC_EN to pass SCL/SDA_IN through 2-flop synchronizers (+2 clk latency).
module i2c_target #(
    parameter logic [6:0] TARGET_ADDR = 7'h2A
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        SCL,
    input  logic        SDA_IN,
    output logic        SDA_OUT,
    output logic        SDA_OE,
    input  logic [15:0] TX_DATA,
    output logic [15:0] RX_DATA,
    output logic        RX_VALID,
    output logic        BUSY
);
    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_BYTE,
        WR_ACK,
        RD_BYTE,
        RD_ACK,
        WAIT_STOP
    } state_t;

    logic scl_cur;
    logic sda_cur;

`ifdef I2C_TARGET_SYNC_EN
    logic [1:0] scl_sync_reg;
    logic [1:0] sda_sync_reg;

    always_ff @(posedge clk) begin
        if (RESET) begin
            scl_sync_reg <= 2'b11;
            sda_sync_reg <= 2'b11;
        end else begin
            scl_sync_reg <= {scl_sync_reg[0], SCL};
            sda_sync_reg <= {sda_sync_reg[0], SDA_IN};
        end
    end

    assign scl_cur = scl_sync_reg[1];
    assign sda_cur = sda_sync_reg[1];
`else
    assign scl_cur = SCL;
    assign sda_cur = SDA_IN;
`endif

    logic scl_prev_reg;
    logic sda_prev_reg;

    // Prev flops reset to the idle-bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (RESET) begin
            scl_prev_reg <= 1'b1;
            sda_prev_reg <= 1'b1;
        end else begin
            scl_prev_reg <= scl_cur;
            sda_prev_reg <= sda_cur;
        end
    end

    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign scl_rise  = scl_cur & ~scl_prev_reg;
    assign scl_fall  = ~scl_cur & scl_prev_reg;
    assign start_det = scl_cur & scl_prev_reg & sda_prev_reg & ~sda_cur;
    assign stop_det  = scl_cur & scl_prev_reg & ~sda_prev_reg & sda_cur;

    state_t      state_reg;
    logic [2:0]  bit_cnt_reg;
    logic        bit9_reg;
    logic        byte_idx_reg;
    logic [15:0] shift_reg;
    logic        rnw_reg;
    logic        ack_reg;
    logic        sda_out_reg;
    logic        sda_oe_reg;
    logic [15:0] rx_data_reg;
    logic        rx_valid_reg;
    logic        busy_reg;

    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg    <= IDLE;
            bit_cnt_reg  <= 3'd0;
            bit9_reg     <= 1'b0;
            byte_idx_reg <= 1'b0;
            shift_reg    <= 16'h0000;
            rnw_reg      <= 1'b0;
            ack_reg      <= 1'b1;
            sda_out_reg  <= 1'b1;
            sda_oe_reg   <= 1'b0;
            rx_data_reg  <= 16'h0000;
            rx_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            rx_valid_reg <= 1'b0;
            if (start_det) begin
                state_reg    <= ADDR;
                bit_cnt_reg  <= 3'd0;
                bit9_reg     <= 1'b0;
                byte_idx_reg <= 1'b0;
                sda_oe_reg   <= 1'b0;
                sda_out_reg  <= 1'b1;
                busy_reg     <= 1'b0;
            end else if (stop_det) begin
                state_reg    <= IDLE;
                bit_cnt_reg  <= 3'd0;
                bit9_reg     <= 1'b0;
                sda_oe_reg   <= 1'b0;
                sda_out_reg  <= 1'b1;
                busy_reg     <= 1'b0;
            end else begin
                // Count data bits on rising edges; bit9_reg marks the 8th bit seen.
                if (scl_rise && !bit9_reg &&
                    (state_reg == ADDR || state_reg == WR_BYTE || state_reg == RD_BYTE)) begin
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        bit9_reg <= 1'b1;
                    end
                    if (state_reg != RD_BYTE) begin
                        shift_reg <= {shift_reg[14:0], sda_cur};
                    end
                end
                if (scl_rise && state_reg == RD_ACK) begin
                    ack_reg <= sda_cur;
                end
                if (scl_fall) begin
                    case (state_reg)
                        ADDR: begin
                            if (bit9_reg) begin
                                bit9_reg <= 1'b0;
                                if (shift_reg[7:1] == TARGET_ADDR) begin
                                    state_reg   <= ADDR_ACK;
                                    rnw_reg     <= shift_reg[0];
                                    sda_oe_reg  <= 1'b1;
                                    sda_out_reg <= 1'b0;
                                    busy_reg    <= 1'b1;
                                end else begin
                                    state_reg <= WAIT_STOP;
                                end
                            end
                        end
                        ADDR_ACK: begin
                            byte_idx_reg <= 1'b0;
                            if (rnw_reg) begin
                                shift_reg   <= TX_DATA;
                                sda_out_reg <= TX_DATA[15];
                                sda_oe_reg  <= 1'b1;
                                state_reg   <= RD_BYTE;
                            end else begin
                                sda_oe_reg  <= 1'b0;
                                sda_out_reg <= 1'b1;
                                state_reg   <= WR_BYTE;
                            end
                        end
                        WR_BYTE: begin
                            if (bit9_reg) begin
                                bit9_reg    <= 1'b0;
                                sda_oe_reg  <= 1'b1;
                                sda_out_reg <= 1'b0;
                                state_reg   <= WR_ACK;
                            end
                        end
                        WR_ACK: begin
                            sda_oe_reg  <= 1'b0;
                            sda_out_reg <= 1'b1;
                            if (!byte_idx_reg) begin
                                byte_idx_reg <= 1'b1;
                                state_reg    <= WR_BYTE;
                            end else begin
                                rx_data_reg  <= shift_reg;
                                rx_valid_reg <= 1'b1;
                                state_reg    <= WAIT_STOP;
                            end
                        end
                        RD_BYTE: begin
                            if (bit9_reg) begin
                                bit9_reg    <= 1'b0;
                                sda_oe_reg  <= 1'b0;
                                sda_out_reg <= 1'b1;
                                state_reg   <= RD_ACK;
                            end else begin
                                sda_out_reg <= shift_reg[14];
                                shift_reg   <= {shift_reg[14:0], 1'b0};
                            end
                        end
                        RD_ACK: begin
                            // Only an ACK after the first byte continues; anything else parks.
                            if (!ack_reg && !byte_idx_reg) begin
                                byte_idx_reg <= 1'b1;
                                sda_out_reg  <= shift_reg[14];
                                shift_reg    <= {shift_reg[14:0], 1'b0};
                                sda_oe_reg   <= 1'b1;
                                state_reg    <= RD_BYTE;
                            end else begin
                                state_reg <= WAIT_STOP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign SDA_OUT  = sda_out_reg;
    assign SDA_OE   = sda_oe_reg;
    assign RX_DATA  = rx_data_reg;
    assign RX_VALID = rx_valid_reg;
    assign BUSY     = busy_reg;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: acts as the bus generator, derives expected target behaviour
// per bit slot from the transfer rules, and checks SDA/BUSY on every SCL-high cycle.
module tb_i2c_target;
    logic        clk = 1'b0;
    logic        RESET;
    logic        SCL;
    logic        SDA_IN;
    logic        SDA_OUT;
    logic        SDA_OE;
    logic [15:0] TX_DATA;
    logic [15:0] RX_DATA;
    logic        RX_VALID;
    logic        BUSY;
    logic        sda_gen;

    int checks = 0;
    int errors = 0;

    logic [15:0] exp_rx = 16'h0000;
    int          exp_pulses = 0;
    logic [15:0] tx_model = 16'h0000;

    int   rv_cycles = 0;
    int   rv_pulses = 0;
    logic rv_prev = 1'b0;

    always #5 clk = ~clk;

    // Open-drain bus: either side can pull low.
    assign SDA_IN = sda_gen & (SDA_OE ? SDA_OUT : 1'b1);

    i2c_target dut (
        .clk      (clk),
        .RESET    (RESET),
        .SCL      (SCL),
        .SDA_IN   (SDA_IN),
        .SDA_OUT  (SDA_OUT),
        .SDA_OE   (SDA_OE),
        .TX_DATA  (TX_DATA),
        .RX_DATA  (RX_DATA),
        .RX_VALID (RX_VALID),
        .BUSY     (BUSY)
    );

    always @(posedge clk) begin
        rv_prev <= RX_VALID;
        if (RX_VALID) rv_cycles <= rv_cycles + 1;
        if (RX_VALID && !rv_prev) rv_pulses <= rv_pulses + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SCL period; target outputs must hold the expected values through the whole high phase.
    task automatic bit_slot(input logic b, input logic e_oe, input logic e_out, input logic e_busy,
                            input string tag, output logic seen);
        wait_n(4);
        sda_gen = b;
        wait_n(4);
        SCL = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check({tag, "_oe"}, SDA_OE, e_oe);
            if (e_oe) check({tag, "_out"}, SDA_OUT, e_out);
            check({tag, "_busy"}, BUSY, e_busy);
            if (i == 3) seen = SDA_IN;
        end
        SCL = 1'b0;
    endtask

    task automatic start_cond();
        if (SCL == 1'b0) begin
            wait_n(4);
            sda_gen = 1'b1;
            wait_n(4);
            SCL = 1'b1;
        end
        wait_n(6);
        sda_gen = 1'b0;
        wait_n(6);
        SCL = 1'b0;
    endtask

    task automatic stop_cond();
        wait_n(4);
        sda_gen = 1'b0;
        wait_n(4);
        SCL = 1'b1;
        wait_n(6);
        sda_gen = 1'b1;
        wait_n(8);
    endtask

    task automatic send_addr(input logic [6:0] a, input logic rnw, output logic m);
        logic [7:0] ab;
        logic s;
        ab = {a, rnw};
        m = (a == 7'h2A);
        start_cond();
        for (int i = 7; i >= 0; i--) bit_slot(ab[i], 1'b0, 1'b1, 1'b0, "addr", s);
        bit_slot(1'b1, m, 1'b0, m, "addr_ack", s);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic active, input logic busy);
        logic s;
        for (int i = 7; i >= 0; i--) bit_slot(d[i], 1'b0, 1'b1, busy, "wr_bit", s);
        bit_slot(1'b1, active, 1'b0, busy, "wr_ack", s);
    endtask

    task automatic read_byte(input int k, input logic active, input logic gen_ack,
                             output logic [7:0] got);
        logic s;
        for (int i = 0; i < 8; i++) begin
            bit_slot(1'b1, active, tx_model[15 - 8*k - i], 1'b1, "rd_bit", s);
            got[7-i] = s;
        end
        bit_slot(gen_ack, 1'b0, 1'b1, 1'b1, "rd_ack", s);
    endtask

    task automatic end_checks(input string tag);
        check({tag, "_rx_data"}, RX_DATA, exp_rx);
        check({tag, "_rv_pulses"}, rv_pulses, exp_pulses);
        check({tag, "_rv_width"}, rv_cycles, exp_pulses);
        check({tag, "_busy_idle"}, BUSY, 1'b0);
        check({tag, "_oe_idle"}, SDA_OE, 1'b0);
    endtask

    initial begin
        logic       m;
        logic [7:0] g0;
        logic [7:0] g1;
        logic       s;

        RESET   = 1'b1;
        SCL     = 1'b1;
        sda_gen = 1'b1;
        TX_DATA = 16'h0000;
        wait_n(4);
        check("rst_oe", SDA_OE, 1'b0);
        check("rst_out", SDA_OUT, 1'b1);
        check("rst_busy", BUSY, 1'b0);
        check("rst_rx_data", RX_DATA, 16'h0000);
        check("rst_rx_valid", RX_VALID, 1'b0);
        RESET = 1'b0;
        wait_n(4);

        // Write 0xBEEF
        send_addr(7'h2A, 1'b0, m);
        write_byte(8'hBE, 1'b1, 1'b1);
        write_byte(8'hEF, 1'b1, 1'b1);
        exp_rx = 16'hBEEF;
        exp_pulses++;
        stop_cond();
        end_checks("write");
        check("write_literal", RX_DATA, 16'hBEEF);
        $display("write addr=2a data=beef rx=%h", RX_DATA);

        // Read 0xA55A, ACK then NACK
        tx_model = 16'hA55A;
        TX_DATA  = tx_model;
        send_addr(7'h2A, 1'b1, m);
        read_byte(0, 1'b1, 1'b0, g0);
        read_byte(1, 1'b1, 1'b1, g1);
        stop_cond();
        end_checks("read");
        check("read_byte0", g0, 8'hA5);
        check("read_byte1", g1, 8'h5A);
        $display("read addr=2a got=%h%h", g0, g1);

        // Address mismatch
        send_addr(7'h2B, 1'b0, m);
        write_byte(8'h11, 1'b0, 1'b0);
        write_byte(8'h22, 1'b0, 1'b0);
        stop_cond();
        end_checks("mismatch");
        $display("write addr=2b (no match) rx=%h", RX_DATA);

        // Aborted write, then full write
        send_addr(7'h2A, 1'b0, m);
        write_byte(8'h12, 1'b1, 1'b1);
        stop_cond();
        end_checks("abort");
        check("abort_literal", RX_DATA, 16'hBEEF);
        $display("write addr=2a data=12 (aborted) rx=%h", RX_DATA);
        send_addr(7'h2A, 1'b0, m);
        write_byte(8'h34, 1'b1, 1'b1);
        write_byte(8'h56, 1'b1, 1'b1);
        exp_rx = 16'h3456;
        exp_pulses++;
        stop_cond();
        end_checks("after_abort");
        check("after_abort_literal", RX_DATA, 16'h3456);
        $display("write addr=2a data=3456 rx=%h", RX_DATA);

        // Third byte gets no ACK
        send_addr(7'h2A, 1'b0, m);
        write_byte(8'h0F, 1'b1, 1'b1);
        write_byte(8'hF0, 1'b1, 1'b1);
        write_byte(8'h99, 1'b0, 1'b1);
        exp_rx = 16'h0FF0;
        exp_pulses++;
        stop_cond();
        end_checks("extra_byte");
        $display("write addr=2a data=0ff0+99 rx=%h", RX_DATA);

        // Read with NACK on byte 0: byte 1 not driven
        tx_model = 16'h9C63;
        TX_DATA  = tx_model;
        send_addr(7'h2A, 1'b1, m);
        read_byte(0, 1'b1, 1'b1, g0);
        read_byte(1, 1'b0, 1'b1, g1);
        stop_cond();
        end_checks("read_nack");
        check("read_nack_byte0", g0, 8'h9C);
        check("read_nack_byte1", g1, 8'hFF);
        $display("read addr=2a nack0 got=%h %h", g0, g1);

        // Reset during ACK of byte 0
        send_addr(7'h2A, 1'b0, m);
        for (int i = 7; i >= 0; i--) bit_slot(1'(8'h77 >> i), 1'b0, 1'b1, 1'b1, "rst_wr", s);
        wait_n(4);
        sda_gen = 1'b1;
        wait_n(4);
        SCL = 1'b1;
        wait_n(3);
        check("rst_mid_pre_oe", SDA_OE, 1'b1);
        check("rst_mid_pre_busy", BUSY, 1'b1);
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        exp_rx = 16'h0000;
        check("rst_mid_oe", SDA_OE, 1'b0);
        check("rst_mid_busy", BUSY, 1'b0);
        check("rst_mid_rx_data", RX_DATA, 16'h0000);
        check("rst_mid_out", SDA_OUT, 1'b1);
        wait_n(4);
        SCL = 1'b0;
        send_addr(7'h2A, 1'b0, m);
        write_byte(8'hC3, 1'b1, 1'b1);
        write_byte(8'h3C, 1'b1, 1'b1);
        exp_rx = 16'hC33C;
        exp_pulses++;
        stop_cond();
        end_checks("post_reset");
        check("post_reset_literal", RX_DATA, 16'hC33C);
        $display("reset mid-write then write data=c33c rx=%h", RX_DATA);

        // Repeated START: write address, then restart as a read
        tx_model = 16'hC01D;
        TX_DATA  = tx_model;
        send_addr(7'h2A, 1'b0, m);
        send_addr(7'h2A, 1'b1, m);
        read_byte(0, 1'b1, 1'b0, g0);
        read_byte(1, 1'b1, 1'b1, g1);
        stop_cond();
        end_checks("rep_start");
        check("rep_start_byte0", g0, 8'hC0);
        check("rep_start_byte1", g1, 8'h1D);
        $display("repeated start read addr=2a got=%h%h", g0, g1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
